// File: rtl/img_stream_loader_if.sv
// Bundles the ROM read port and the pixel output stream of img_stream_loader.
// The master modport is the loader's view; the slave modport is the ROM/consumer side.
interface img_stream_loader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  logic              o_rom_ce;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic              i_next;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_frame_done;

  modport master (
    output o_rom_ce, o_rom_addr, o_data, o_valid, o_frame_done,
    input  i_rom_data, i_next
  );

  modport slave (
    input  o_rom_ce, o_rom_addr, o_data, o_valid, o_frame_done,
    output i_rom_data, i_next
  );
endinterface

// File: rtl/img_stream_loader.sv
// ROM-to-pixel streamer: fetches an image from a synchronous ROM into a FIFO and
// emits it with per-axis integer upscaling (1..4), framed by an active-low vsync.
module img_stream_loader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned IMG_W      = 225,
  parameter int unsigned IMG_H      = 225,
  parameter int unsigned START_ADDR = 10,
  parameter int unsigned FIFO_AW    = 8,
  parameter int unsigned ROM_LAT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vsync,
  input  logic [2:0]          i_hscale,
  input  logic [2:0]          i_vscale,
  img_stream_loader_if.master bus
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned INF_W = $clog2(ROM_LAT + 1);

  function automatic logic [2:0] clamp_scale(input logic [2:0] s);
    if (s == 3'd0) return 3'd1;
    if (s > 3'd4)  return 3'd4;
    return s;
  endfunction

  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_row_start;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [2:0]         r_pass;
  logic [2:0]         r_hscale;
  logic [2:0]         r_vscale;
  logic [2:0]         r_hcnt;
  logic               r_fetch_done;
  logic [ROM_LAT-1:0] r_vld_sr;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;

  logic [INF_W-1:0]   w_inflight;
  logic [31:0]        w_occ;
  logic               w_credit;
  logic               w_ce;
  logic               w_wr;
  logic               w_acc;
  logic               w_pop;
  logic               w_last_col;
  logic               w_last_pass;
  logic               w_last_row;

  // Reads already issued but not yet written still reserve FIFO space.
  assign w_inflight  = INF_W'($countones(r_vld_sr));
  assign w_occ       = 32'(r_cnt) + 32'(w_inflight);
  assign w_credit    = (w_occ < 32'(DEPTH));
  assign w_ce        = rst_n & i_vsync & ~r_fetch_done & w_credit;
  assign w_wr        = rst_n & i_vsync & r_vld_sr[ROM_LAT-1];
  assign w_acc       = bus.i_next & bus.o_valid;
  assign w_pop       = w_acc & (r_hcnt == (r_hscale - 3'd1));
  assign w_last_col  = (r_col == COL_W'(IMG_W - 1));
  assign w_last_pass = (r_pass == (r_vscale - 3'd1));
  assign w_last_row  = (r_row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !i_vsync) begin
      r_addr       <= ADDR_W'(START_ADDR);
      r_row_start  <= ADDR_W'(START_ADDR);
      r_col        <= '0;
      r_row        <= '0;
      r_pass       <= '0;
      r_hcnt       <= '0;
      r_fetch_done <= 1'b0;
      r_vld_sr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      // Vsync low latches the next frame's scales; reset forces 1x.
      r_hscale     <= rst_n ? clamp_scale(i_hscale) : 3'd1;
      r_vscale     <= rst_n ? clamp_scale(i_vscale) : 3'd1;
    end else begin
      r_vld_sr[0] <= w_ce;
      for (int k = 1; k < ROM_LAT; k++) r_vld_sr[k] <= r_vld_sr[k-1];

      if (w_ce) begin
        if (!w_last_col) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_col  <= r_col + COL_W'(1);
        end else if (!w_last_pass) begin
          r_addr <= r_row_start;
          r_col  <= '0;
          r_pass <= r_pass + 3'd1;
        end else if (!w_last_row) begin
          r_row_start <= r_row_start + ADDR_W'(IMG_W);
          r_addr      <= r_row_start + ADDR_W'(IMG_W);
          r_col       <= '0;
          r_pass      <= '0;
          r_row       <= r_row + ROW_W'(1);
        end else begin
          r_fetch_done <= 1'b1;
        end
      end

      if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      if (w_acc) r_hcnt   <= w_pop ? 3'd0 : r_hcnt + 3'd1;

      unique case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.i_rom_data;
  end

  assign bus.o_rom_ce     = w_ce;
  assign bus.o_rom_addr   = r_addr;
  assign bus.o_data       = r_mem[r_rd_ptr];
  assign bus.o_valid      = (r_cnt != '0);
  assign bus.o_frame_done = r_fetch_done & (w_inflight == '0) & (r_cnt == '0);

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed bench for img_stream_loader on a 4x3 image with an 8-deep FIFO and ROM[a]=a.
module tb_img_stream_loader;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 3;
  localparam int unsigned SADDR  = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_vsync;
  logic [2:0] i_hscale;
  logic [2:0] i_vscale;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] rom_p1, rom_p2;

  img_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  img_stream_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .START_ADDR(SADDR), .FIFO_AW(3), .ROM_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_vsync(i_vsync),
    .i_hscale(i_hscale), .i_vscale(i_vscale), .bus(bus)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous ROM holding its own address.
  always @(posedge clk) begin
    rom_p1 <= bus.o_rom_addr;
    rom_p2 <= rom_p1;
  end
  assign bus.i_rom_data = rom_p2[DATA_W-1:0];

  function automatic void build_exp(input int h, input int v);
    exp_q.delete();
    for (int r = 0; r < IMG_H; r++)
      for (int p = 0; p < v; p++)
        for (int c = 0; c < IMG_W; c++)
          for (int k = 0; k < h; k++) exp_q.push_back(DATA_W'(SADDR + r * IMG_W + c));
  endfunction

  task automatic start_frame(input logic [2:0] h, input logic [2:0] v);
    i_vsync  = 1'b0;
    i_hscale = h;
    i_vscale = v;
    @(negedge clk);
    i_vsync = 1'b1;
    #1;
  endtask

  task automatic collect(input int budget, output int n_ce, output bit done_seen);
    got.delete();
    n_ce = 0;
    done_seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.o_frame_done) begin
        done_seen = 1'b1;
        break;
      end
      if (bus.o_rom_ce) n_ce++;
      if (bus.o_valid && bus.i_next) got.push_back(bus.o_data);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_vsync = 1'b1; i_hscale = 3'd3; i_vscale = 3'd3; bus.i_next = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.o_rom_ce !== 1'b0) begin
      n_errors++; $display("FAIL reset_ce: got %b want 0", bus.o_rom_ce);
    end
    n_checks++;
    if (bus.o_rom_addr !== 16'd10) begin
      n_errors++; $display("FAIL reset_addr: got %0d want 10", bus.o_rom_addr);
    end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid);
    end
    n_checks++;
    if (bus.o_frame_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_done: got %b want 0", bus.o_frame_done);
    end
    rst_n = 1'b1;
    i_vsync = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_scale_1x1();
    int n_ce; bit done;
    bus.i_next = 1'b1;
    start_frame(3'd1, 3'd1);
    build_exp(1, 1);
    collect(500, n_ce, done);
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL s11_done: got timeout want frame_done"); end
    n_checks++;
    if (n_ce != 12) begin n_errors++; $display("FAIL s11_ce_count: got %0d want 12", n_ce); end
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_errors++; $display("FAIL s11_len: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL s11_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.o_frame_done !== 1'b1 || bus.o_rom_ce !== 1'b0) begin
        n_errors++;
        $display("FAIL s11_hold: got done=%b ce=%b want done=1 ce=0",
                 bus.o_frame_done, bus.o_rom_ce);
      end
    end
  endtask

  task automatic test_scale_2x2();
    int n_ce; bit done;
    bus.i_next = 1'b1;
    start_frame(3'd2, 3'd2);
    build_exp(2, 2);
    collect(1000, n_ce, done);
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL s22_done: got timeout want frame_done"); end
    n_checks++;
    if (n_ce != 24) begin n_errors++; $display("FAIL s22_ce_count: got %0d want 24", n_ce); end
    n_checks++;
    if (got.size() != 48) begin n_errors++; $display("FAIL s22_len: got %0d want 48", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL s22_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_ce; int stall_ce; bit done;
    bus.i_next = 1'b0;
    start_frame(3'd1, 3'd1);
    stall_ce = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_rom_ce) stall_ce++;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (stall_ce != 8) begin n_errors++; $display("FAIL bp_ce_count: got %0d want 8", stall_ce); end
    n_checks++;
    if (bus.o_rom_ce !== 1'b0) begin n_errors++; $display("FAIL bp_ce_held: got %b want 0", bus.o_rom_ce); end
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 8'd10) begin
      n_errors++; $display("FAIL bp_head: got v=%b d=%0d want v=1 d=10", bus.o_valid, bus.o_data);
    end
    bus.i_next = 1'b1;
    build_exp(1, 1);
    collect(500, n_ce, done);
    n_checks++;
    if (!done || n_ce != 4) begin
      n_errors++; $display("FAIL bp_resume: got done=%0d ce=%0d want done=1 ce=4", done, n_ce);
    end
    n_checks++;
    if (got.size() != 12) begin n_errors++; $display("FAIL bp_len: got %0d want 12", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL bp_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_vsync_abort();
    int n_ce; bit done;
    bus.i_next = 1'b1;
    start_frame(3'd1, 3'd1);
    @(negedge clk);
    @(negedge clk);
    // Two reads are in flight here; neither may reach the FIFO.
    i_vsync = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.o_valid !== 1'b0) begin
        n_errors++; $display("FAIL abort_valid[%0d]: got %b want 0", c, bus.o_valid);
      end
    end
    i_vsync = 1'b1;
    #1;
    build_exp(1, 1);
    collect(500, n_ce, done);
    n_checks++;
    if (!done || got.size() != 12) begin
      n_errors++; $display("FAIL abort_len: got done=%0d n=%0d want done=1 n=12", done, got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL abort_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n_ce; bit done;
    bus.i_next = 1'b1;
    start_frame(3'd3, 3'd2);
    for (int c = 0; c < 10; c++) @(negedge clk);
    rst_n = 1'b0;
    i_hscale = 3'd3;
    #1;
    n_checks++;
    if (bus.o_rom_ce !== 1'b0) begin n_errors++; $display("FAIL rstm_ce: got %b want 0", bus.o_rom_ce); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.o_rom_addr !== 16'd10 || bus.o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rstm_state: got addr=%0d v=%b want addr=10 v=0", bus.o_rom_addr, bus.o_valid);
    end
    build_exp(1, 1);
    collect(500, n_ce, done);
    n_checks++;
    if (!done || got.size() != 12) begin
      n_errors++; $display("FAIL rstm_len: got done=%0d n=%0d want done=1 n=12", done, got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL rstm_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_scale_clamp();
    int n_ce; bit done;
    bus.i_next = 1'b1;
    start_frame(3'd0, 3'd7);
    build_exp(1, 4);
    collect(1000, n_ce, done);
    n_checks++;
    if (!done || n_ce != 48) begin
      n_errors++; $display("FAIL clamp_done: got done=%0d ce=%0d want done=1 ce=48", done, n_ce);
    end
    n_checks++;
    if (got.size() != 48) begin n_errors++; $display("FAIL clamp_len: got %0d want 48", got.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL clamp_pix[%0d]: got %0d want %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scale_1x1();
    test_scale_2x2();
    test_backpressure();
    test_vsync_abort();
    test_reset_midframe();
    test_scale_clamp();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
